// File: rtl/led_status_pkg.sv
// Shared types and helpers for the status LED sequencer and its ms prescaler.
// Optional feature macro: LED_STATUS_LAMP_TEST_EN (adds the LAMP state).
package led_status_pkg;

    localparam int unsigned STATE_W = 3;
    localparam int unsigned TIMER_W = 16;

    localparam logic [STATE_W-1:0] ENC_IDLE     = 3'd0;
    localparam logic [STATE_W-1:0] ENC_ACTIVITY = 3'd1;
    localparam logic [STATE_W-1:0] ENC_BUSY     = 3'd2;
    localparam logic [STATE_W-1:0] ENC_DONE     = 3'd3;
    localparam logic [STATE_W-1:0] ENC_ERROR    = 3'd4;
    localparam logic [STATE_W-1:0] ENC_LAMP     = 3'd5;

    localparam logic [TIMER_W-1:0] TIMER_MAX = '1;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE     = ENC_IDLE,
        ST_ACTIVITY = ENC_ACTIVITY,
        ST_BUSY     = ENC_BUSY,
        ST_DONE     = ENC_DONE,
        ST_ERROR    = ENC_ERROR,
        ST_LAMP     = ENC_LAMP
    } state_e;

    // Terminal count of the ms prescaler: clocks per ms minus one.
    function automatic int unsigned presc_tc(input int unsigned clock_speed);
        return (clock_speed / 1000) - 1;
    endfunction

    // Counter width needed to hold 0..presc_tc, never less than one bit.
    function automatic int unsigned presc_width(input int unsigned clock_speed);
        int unsigned w;
        w = int'($clog2(clock_speed / 1000));
        return (w == 0) ? 1 : w;
    endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Free-running millisecond prescaler; ms_tick_c is high for the one cycle
// in which the counter wraps.
module ms_tick_gen
    import led_status_pkg::*;
#(
    parameter int unsigned CLOCK_SPEED = 25000000
) (
    input  logic clock,
    input  logic reset_n,
    output logic ms_tick_c
);

    localparam int unsigned PRESC_W  = presc_width(CLOCK_SPEED);
    localparam int unsigned PRESC_TC = presc_tc(CLOCK_SPEED);

    logic [PRESC_W-1:0] cnt_q;
    logic [PRESC_W-1:0] cnt_d;
    logic               wrap;

    // Next count: wrap to zero at the terminal count.
    always_comb begin
        wrap  = (cnt_q == PRESC_W'(PRESC_TC));
        cnt_d = wrap ? '0 : cnt_q + PRESC_W'(1);
    end

    // Prescaler register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign ms_tick_c = wrap;

endmodule

// File: rtl/led_status_sequencer.sv
// Turns bootloader event pulses and busy levels into exclusive LED mode
// strobes with priority, minimum display times and sticky error indication.
// Optional feature macro: LED_STATUS_LAMP_TEST_EN (lamp test after reset).
module led_status_sequencer
    import led_status_pkg::*;
#(
    parameter int unsigned CLOCK_SPEED  = 25000000,
    parameter int unsigned ACT_HOLD_MS  = 50,
    parameter int unsigned DONE_HOLD_MS = 2000,
    parameter int unsigned MIN_BUSY_MS  = 200
`ifdef LED_STATUS_LAMP_TEST_EN
    ,
    parameter int unsigned LAMP_TEST_MS = 500
`endif
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               rx_pulse,
    input  logic               erase_busy,
    input  logic               program_busy,
    input  logic               done_pulse,
    input  logic               error_pulse,
    input  logic               error_clear,
    output logic               on,
    output logic               slow_flash,
    output logic               fast_flash,
    output logic [STATE_W-1:0] state_out
);

    state_e               state_q, state_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic                 done_latch_q, done_latch_d;
    logic                 on_q, on_d;
    logic                 slow_q, slow_d;
    logic                 fast_q, fast_d;
    logic                 busy;
    logic                 restart;
    logic                 ms_tick_c;
`ifdef LED_STATUS_LAMP_TEST_EN
    logic                 lamp_pending_q, lamp_pending_d;
`endif

    ms_tick_gen #(
        .CLOCK_SPEED (CLOCK_SPEED)
    ) u_ms_tick_gen (
        .clock     (clock),
        .reset_n   (reset_n),
        .ms_tick_c (ms_tick_c)
    );

    // Next state, done latch, ms timer and decoded mode strobes.
    always_comb begin
        state_d      = state_q;
        done_latch_d = done_latch_q;
        restart      = 1'b0;
        busy         = erase_busy | program_busy;
`ifdef LED_STATUS_LAMP_TEST_EN
        lamp_pending_d = 1'b0;
`endif

        if (error_pulse) begin
            state_d      = ST_ERROR;
            done_latch_d = 1'b0;
            restart      = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (busy) begin
                        state_d = ST_BUSY;
                    end else if (done_pulse) begin
                        state_d = ST_DONE;
                    end else if (rx_pulse) begin
                        state_d = ST_ACTIVITY;
                    end
`ifdef LED_STATUS_LAMP_TEST_EN
                    // First cycle out of reset runs the lamp test instead.
                    if (lamp_pending_q) begin
                        state_d = ST_LAMP;
                    end
`endif
                end
                ST_ACTIVITY: begin
                    if (busy) begin
                        state_d = ST_BUSY;
                    end else if (done_pulse) begin
                        state_d = ST_DONE;
                    end else if (rx_pulse) begin
                        restart = 1'b1;
                    end else if (timer_q == TIMER_W'(ACT_HOLD_MS)) begin
                        state_d = ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    if (done_pulse) begin
                        done_latch_d = 1'b1;
                    end
                    // A done pulse on the exit cycle still shows DONE.
                    if (!busy && (timer_q >= TIMER_W'(MIN_BUSY_MS))) begin
                        state_d      = (done_latch_q || done_pulse) ? ST_DONE : ST_IDLE;
                        done_latch_d = 1'b0;
                    end
                end
                ST_DONE: begin
                    if (busy) begin
                        state_d = ST_BUSY;
                    end else if (timer_q == TIMER_W'(DONE_HOLD_MS)) begin
                        state_d = ST_IDLE;
                    end
                end
                ST_ERROR: begin
                    if (error_clear) begin
                        state_d = ST_IDLE;
                    end
                end
`ifdef LED_STATUS_LAMP_TEST_EN
                ST_LAMP: begin
                    if (timer_q == TIMER_W'(LAMP_TEST_MS)) begin
                        state_d = ST_IDLE;
                    end
                end
`endif
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        if ((state_d != state_q) || restart) begin
            timer_d = '0;
        end else if (ms_tick_c && (timer_q != TIMER_MAX)) begin
            timer_d = timer_q + TIMER_W'(1);
        end else begin
            timer_d = timer_q;
        end

        on_d   = (state_d == ST_ACTIVITY) || (state_d == ST_DONE);
        slow_d = (state_d == ST_BUSY);
        fast_d = (state_d == ST_ERROR);
`ifdef LED_STATUS_LAMP_TEST_EN
        if (state_d == ST_LAMP) begin
            on_d = 1'b1;
        end
`endif
    end

    // State, timer, latch and output registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            timer_q      <= '0;
            done_latch_q <= 1'b0;
            on_q         <= 1'b0;
            slow_q       <= 1'b0;
            fast_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            done_latch_q <= done_latch_d;
            on_q         <= on_d;
            slow_q       <= slow_d;
            fast_q       <= fast_d;
        end
    end

`ifdef LED_STATUS_LAMP_TEST_EN
    // Remembers that the lamp test has not yet run since reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            lamp_pending_q <= 1'b1;
        end else begin
            lamp_pending_q <= lamp_pending_d;
        end
    end
`endif

    assign on         = on_q;
    assign slow_flash = slow_q;
    assign fast_flash = fast_q;
    assign state_out  = state_q;

endmodule

// File: tb/tb_led_status_sequencer.sv
// Bench for led_status_sequencer at 10 clocks per ms (default build).
// The reference model tracks the displayed mode and the time of entry into
// it, and derives elapsed milliseconds from the clock count.
module tb_led_status_sequencer;

    localparam int unsigned CLK_HZ = 10000;
    localparam int CPM = 10;

    localparam int M_IDLE = 0;
    localparam int M_ACT  = 1;
    localparam int M_BUSY = 2;
    localparam int M_DONE = 3;
    localparam int M_ERR  = 4;

    localparam int ACT_MS  = 50;
    localparam int DONE_MS = 2000;
    localparam int BUSY_MS = 200;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       rx_pulse = 1'b0;
    logic       erase_busy = 1'b0;
    logic       program_busy = 1'b0;
    logic       done_pulse = 1'b0;
    logic       error_pulse = 1'b0;
    logic       error_clear = 1'b0;
    logic       on;
    logic       slow_flash;
    logic       fast_flash;
    logic [2:0] state_out;

    int checks = 0;
    int errors = 0;

    int m_mode;
    int m_entry;
    int m_edge;
    bit m_latch;

    led_status_sequencer #(
        .CLOCK_SPEED (CLK_HZ)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .rx_pulse     (rx_pulse),
        .erase_busy   (erase_busy),
        .program_busy (program_busy),
        .done_pulse   (done_pulse),
        .error_pulse  (error_pulse),
        .error_clear  (error_clear),
        .on           (on),
        .slow_flash   (slow_flash),
        .fast_flash   (fast_flash),
        .state_out    (state_out)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_range(input string tag, input int val, input int lo, input int hi);
        checks++;
        assert (val >= lo && val <= hi) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d..%0d", tag, val, lo, hi);
        end
    endtask

    task automatic model_reset();
        m_mode  = M_IDLE;
        m_entry = 0;
        m_edge  = 0;
        m_latch = 1'b0;
    endtask

    // Apply the sampled inputs at one clock edge.
    task automatic model_step();
        int  ms;
        int  nm;
        bit  restart;
        bit  busy;
        m_edge++;
        // Whole ms boundaries (every CPM-th clock) crossed since entry.
        ms      = (m_edge - 1) / CPM - m_entry / CPM;
        nm      = m_mode;
        restart = 1'b0;
        busy    = erase_busy || program_busy;
        if (error_pulse) begin
            nm      = M_ERR;
            m_latch = 1'b0;
            restart = 1'b1;
        end else if (m_mode == M_ERR) begin
            if (error_clear) nm = M_IDLE;
        end else if (m_mode == M_BUSY) begin
            if (done_pulse) m_latch = 1'b1;
            if (!busy && ms >= BUSY_MS) begin
                nm      = m_latch ? M_DONE : M_IDLE;
                m_latch = 1'b0;
            end
        end else if (busy) begin
            nm = M_BUSY;
        end else if (done_pulse && (m_mode == M_IDLE || m_mode == M_ACT)) begin
            nm = M_DONE;
        end else if (rx_pulse && m_mode == M_IDLE) begin
            nm = M_ACT;
        end else if (rx_pulse && m_mode == M_ACT) begin
            restart = 1'b1;
        end else if (m_mode == M_ACT && ms == ACT_MS) begin
            nm = M_IDLE;
        end else if (m_mode == M_DONE && ms == DONE_MS) begin
            nm = M_IDLE;
        end
        if (nm != m_mode || restart) m_entry = m_edge;
        m_mode = nm;
    endtask

    function automatic logic [31:0] expected_vec();
        logic [2:0] st;
        logic       e_on, e_slow, e_fast;
        st     = 3'(m_mode);
        e_on   = (m_mode == M_ACT) || (m_mode == M_DONE);
        e_slow = (m_mode == M_BUSY);
        e_fast = (m_mode == M_ERR);
        return 32'({st, e_on, e_slow, e_fast});
    endfunction

    // One clock: model follows the edge, DUT checked 1 time unit later.
    task automatic cycle();
        @(posedge clock);
        model_step();
        #1;
        chk("model", 32'({state_out, on, slow_flash, fast_flash}), expected_vec());
    endtask

    initial begin
        int n;

        // Reset state
        model_reset();
        #23;
        chk("reset_outputs", 32'({state_out, on, slow_flash, fast_flash}), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;

        // Idle with no stimulus
        repeat (1000) cycle();
        chk("idle_quiet", 32'({on, slow_flash, fast_flash}), 32'd0);

        // Activity and retrigger
        repeat ($urandom_range(1, 15)) cycle();
        rx_pulse = 1'b1; cycle(); rx_pulse = 1'b0;
        chk("act_on", 32'(on), 32'd1);
        repeat (299) cycle();
        rx_pulse = 1'b1; cycle(); rx_pulse = 1'b0;
        chk("act_retrig_on", 32'(on), 32'd1);
        n = 1;
        while (on === 1'b1 && n < 1000) begin cycle(); n++; end
        chk_range("act_hold", n - 1, 490, 502);

        // Busy minimum hold
        repeat ($urandom_range(1, 15)) cycle();
        erase_busy = 1'b1; cycle();
        chk("busy_slow", 32'(slow_flash), 32'd1);
        repeat (19) cycle();
        erase_busy = 1'b0;
        n = 20;
        while (slow_flash === 1'b1 && n < 3000) begin cycle(); n++; end
        chk_range("busy_hold", n - 1, 1990, 2002);
        chk("busy_exit_idle", 32'({state_out, on, slow_flash, fast_flash}), 32'd0);

        // Busy then done
        repeat ($urandom_range(1, 15)) cycle();
        program_busy = 1'b1;
        repeat (50) cycle();
        done_pulse = 1'b1; cycle(); done_pulse = 1'b0;
        chk("done_during_busy", 32'(slow_flash), 32'd1);
        repeat (49) cycle();
        program_busy = 1'b0;
        n = 0;
        while (slow_flash === 1'b1 && n < 3000) begin cycle(); n++; end
        chk("done_after_busy", 32'({state_out, on}), 32'({3'd3, 1'b1}));
        n = 1;
        while (on === 1'b1 && n < 21000) begin cycle(); n++; end
        chk_range("done_hold", n - 1, 19990, 20002);

        // Error priority and stickiness
        error_pulse = 1'b1; error_clear = 1'b1; cycle();
        error_pulse = 1'b0; error_clear = 1'b0;
        chk("err_wins_clear", 32'({state_out, fast_flash}), 32'({3'd4, 1'b1}));
        erase_busy = 1'b1;
        for (int i = 0; i < 50; i++) begin
            rx_pulse   = (i % 10 == 0);
            done_pulse = (i == 25);
            cycle();
        end
        rx_pulse = 1'b0; done_pulse = 1'b0; erase_busy = 1'b0;
        chk("err_sticky", 32'({state_out, on, slow_flash, fast_flash}), 32'({3'd4, 3'b001}));
        cycle();
        error_clear = 1'b1; cycle(); error_clear = 1'b0;
        chk("err_cleared", 32'({state_out, on, slow_flash, fast_flash}), 32'd0);

        // Randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            rx_pulse    = ($urandom_range(0, 39) == 0);
            done_pulse  = ($urandom_range(0, 299) == 0);
            error_pulse = ($urandom_range(0, 999) == 0);
            error_clear = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 199) == 0) erase_busy = ~erase_busy;
            if ($urandom_range(0, 299) == 0) program_busy = ~program_busy;
            cycle();
        end
        rx_pulse = 1'b0; done_pulse = 1'b0; error_pulse = 1'b0;
        error_clear = 1'b0; program_busy = 1'b0;

        // Asynchronous reset mid-BUSY
        erase_busy = 1'b1;
        repeat (30) cycle();
        chk("pre_reset_busy", 32'({state_out, slow_flash}), 32'({3'd2, 1'b1}));
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_reset", 32'({state_out, on, slow_flash, fast_flash}), 32'd0);
        model_reset();
        erase_busy = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        repeat (1000) cycle();
        chk("post_reset_quiet", 32'({state_out, on, slow_flash, fast_flash}), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
